// File: rtl/pong_pkg.sv
// Shared types and cell geometry for the pong score overlay.
package pong_pkg;

    localparam int unsigned GLYPH_XBITS = 2;
    localparam int unsigned GLYPH_YBITS = 3;
    localparam int unsigned DIGIT_BITS  = 4;

    typedef logic [DIGIT_BITS-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_score_t;

    function automatic int unsigned cell_w(input int unsigned scale);
        return 4 << scale;
    endfunction

    function automatic int unsigned cell_h(input int unsigned scale);
        return 8 << scale;
    endfunction

    function automatic bcd_score_t bcd_inc(input bcd_score_t s);
        bcd_score_t r;
        r = s;
        if (s.ones == 4'd9) begin
            r.ones = '0;
            r.tens = (s.tens == 4'd9) ? '0 : s.tens + 4'd1;
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD point counter with synchronous clear and hold.
module pong_bcd_score
    import pong_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic       hold_i,
    output bcd_score_t score_o
);

    bcd_score_t score_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q <= '0;
        end else if (clr_i) begin
            score_q <= '0;
        end else if (inc_i && !hold_i) begin
            score_q <= bcd_inc(score_q);
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/pong_score_display.sv
// Score overlay: live/display BCD scores, beam-to-glyph address issue and
// a three-stage pixel pipeline aligned with the external glyph lookup.
module pong_score_display
    import pong_pkg::*;
#(
    parameter int unsigned SCALE     = 2,
    parameter int unsigned LEFT_X    = 256,
    parameter int unsigned RIGHT_X   = 352,
    parameter int unsigned TOP_Y     = 16,
    parameter logic [7:0]  WIN_SCORE = 8'h11,
    parameter int unsigned H_BITS    = 10,
    parameter int unsigned V_BITS    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [H_BITS-1:0]      hcount,
    input  logic [V_BITS-1:0]      vcount,
    input  logic                   frame_start,
    input  logic                   point_left,
    input  logic                   point_right,
    input  logic                   game_reset,
    output logic [GLYPH_XBITS-1:0] glyph_x,
    output logic [GLYPH_YBITS-1:0] glyph_y,
    output logic [DIGIT_BITS-1:0]  glyph_value,
    input  logic                   glyph_pixel,
    output logic                   score_pixel,
    output logic                   game_over
);

    localparam int unsigned CELL_W = cell_w(SCALE);
    localparam int unsigned CELL_H = cell_h(SCALE);

    bcd_score_t live_l, live_r;
    bcd_score_t disp_l_q, disp_r_q;
    logic       game_over_q;
    logic       in_box_q, in_box_dly_q, score_pixel_q;
    logic       in_box_d;

    logic [GLYPH_XBITS-1:0] glyph_x_q, glyph_x_d;
    logic [GLYPH_YBITS-1:0] glyph_y_q, glyph_y_d;
    logic [DIGIT_BITS-1:0]  glyph_value_q, glyph_value_d;

    pong_bcd_score u_left (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (point_left),
        .clr_i  (game_reset),
        .hold_i (game_over_q),
        .score_o(live_l)
    );

    pong_bcd_score u_right (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (point_right),
        .clr_i  (game_reset),
        .hold_i (game_over_q),
        .score_o(live_r)
    );

    int unsigned hc, vc, rel_x, rel_y;
    bcd_score_t  sel;
    logic        hit, in_y;
    bcd_digit_t  digit;

    // Range checks are done before subtracting so rel never wraps negative.
    always_comb begin
        hc    = 32'(hcount);
        vc    = 32'(vcount);
        in_y  = (vc >= TOP_Y) && (vc < TOP_Y + CELL_H);
        rel_y = in_y ? vc - TOP_Y : 0;
        rel_x = 0;
        sel   = '0;
        hit   = 1'b0;
        if (in_y && hc >= LEFT_X && hc < LEFT_X + 2 * CELL_W) begin
            hit   = 1'b1;
            rel_x = hc - LEFT_X;
            sel   = disp_l_q;
        end else if (in_y && hc >= RIGHT_X && hc < RIGHT_X + 2 * CELL_W) begin
            hit   = 1'b1;
            rel_x = hc - RIGHT_X;
            sel   = disp_r_q;
        end
        digit = (rel_x >= CELL_W) ? sel.ones : sel.tens;
        if (rel_x < CELL_W && sel.tens == '0) begin
            hit = 1'b0;
        end
        in_box_d      = hit;
        glyph_x_d     = hit ? GLYPH_XBITS'(rel_x >> SCALE) : '0;
        glyph_y_d     = hit ? GLYPH_YBITS'(rel_y >> SCALE) : '0;
        glyph_value_d = hit ? digit : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_l_q      <= '0;
            disp_r_q      <= '0;
            game_over_q   <= 1'b0;
            glyph_x_q     <= '0;
            glyph_y_q     <= '0;
            glyph_value_q <= '0;
            in_box_q      <= 1'b0;
            in_box_dly_q  <= 1'b0;
            score_pixel_q <= 1'b0;
        end else begin
            if (game_reset) begin
                game_over_q <= 1'b0;
            end else if (live_l == WIN_SCORE || live_r == WIN_SCORE) begin
                game_over_q <= 1'b1;
            end
            if (frame_start) begin
                disp_l_q <= live_l;
                disp_r_q <= live_r;
            end
            glyph_x_q     <= glyph_x_d;
            glyph_y_q     <= glyph_y_d;
            glyph_value_q <= glyph_value_d;
            in_box_q      <= in_box_d;
            in_box_dly_q  <= in_box_q;
            score_pixel_q <= glyph_pixel & in_box_dly_q;
        end
    end

    assign glyph_x     = glyph_x_q;
    assign glyph_y     = glyph_y_q;
    assign glyph_value = glyph_value_q;
    assign score_pixel = score_pixel_q;
    assign game_over   = game_over_q;

endmodule
